// File: rtl/i2c_sched_pkg.sv
// Shared types and constants for the I2C sensor scheduler: FSM encoding,
// packet field widths and the fixed per-slot sensor table.
package i2c_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        COLLECT = 2'd2,
        EMIT    = 2'd3
    } state_t;

    localparam int PAYLOAD_W = 48;
    localparam int TS_W      = 24;
    localparam int ID_W      = 8;
    localparam int PKT_W     = PAYLOAD_W + TS_W + ID_W;
    localparam int MAX_SLOTS = 3;

    typedef struct packed {
        logic [6:0] dev_addr;
        logic [7:0] reg_addr;
        logic [2:0] len;
        logic [7:0] id;
    } slot_cfg_t;

    function automatic slot_cfg_t slot_cfg(input logic [1:0] idx);
        slot_cfg_t cfg;
        case (idx)
            2'd0:    cfg = '{dev_addr: 7'h1E, reg_addr: 8'h03, len: 3'd6, id: 8'h4D};
            2'd1:    cfg = '{dev_addr: 7'h77, reg_addr: 8'hF7, len: 3'd6, id: 8'h42};
            2'd2:    cfg = '{dev_addr: 7'h68, reg_addr: 8'h3B, len: 3'd6, id: 8'h41};
            default: cfg = '0;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/i2c_sensor_scheduler_rr_arbiter3.sv
// Three-way round-robin arbiter: picks the first pending slot at or after ptr,
// wrapping around. Purely combinational.
module rr_arbiter3 (
    input  logic [2:0] pending,
    input  logic [1:0] ptr,
    output logic [2:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] cand_idx [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cand
            logic [2:0] sum;
            assign sum          = {1'b0, ptr} + 3'(gi);
            assign cand_idx[gi] = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest pending slot wins.
    always_comb begin
        grant_idx = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (pending[cand_idx[i]]) begin
                grant_idx = cand_idx[i];
            end
        end
        grant = (|pending) ? (3'b001 << grant_idx) : 3'b000;
    end

endmodule

// File: rtl/i2c_sensor_scheduler.sv
// Periodic I2C sensor scheduler: round-robin reads of up to three sensors,
// packetised as {payload, timestamp, id}. Optional watchdog: I2C_SCHED_TIMEOUT_EN.
module i2c_sensor_scheduler
    import i2c_sched_pkg::*;
#(
    parameter int NUM_SLOTS      = 3,
    parameter int PERIOD_CYCLES  = 100000,
    parameter int MAX_RETRY      = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [TS_W-1:0]      timestamp,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic [6:0]           cmd_dev_addr,
    output logic [7:0]           cmd_reg_addr,
    output logic [2:0]           cmd_len,
    input  logic                 rd_valid,
    input  logic [7:0]           rd_data,
    input  logic                 xfer_done,
    input  logic                 xfer_nack,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [PKT_W-1:0]     pkt_data,
    output logic                 busy,
    output logic [7:0]           err_count
);

    localparam int PER_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [2:0] SLOT_MASK = 3'((1 << NUM_SLOTS) - 1);

    state_t                 state_reg, state_next;
    logic [PER_W-1:0]       period_cnt_reg;
    logic                   period_wrap;
    logic [2:0]             pending_reg, pending_next;
    logic [1:0]             ptr_reg, ptr_next;
    logic [1:0]             grant_reg;
    logic [7:0]             retry_reg;
    logic [2:0]             byte_idx_reg;
    logic [2:0]             byte_idx_eff;
    logic [TS_W-1:0]        ts_reg;
    logic [ID_W-1:0]        slot_id_reg;
    logic [7:0]             payload_bytes [6];
    logic [PAYLOAD_W-1:0]   payload_flat;

    logic [2:0]             arb_grant;
    logic [1:0]             arb_idx;
    slot_cfg_t              arb_cfg;

    logic grant_load, issue_hs, store, fail, retry_go, drop, emit_hs;
    logic short_read, timeout_hit;

    rr_arbiter3 u_arb (
        .pending   (pending_reg),
        .ptr       (ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign arb_cfg      = slot_cfg(arb_idx);
    assign period_wrap  = (period_cnt_reg == PER_W'(PERIOD_CYCLES - 1));
    assign store        = (state_reg == COLLECT) && rd_valid && (byte_idx_reg < cmd_len);
    assign byte_idx_eff = byte_idx_reg + {2'b00, store};
    assign short_read   = (byte_idx_eff != cmd_len);
    assign ptr_next     = (int'(grant_reg) + 1 >= NUM_SLOTS) ? 2'd0 : grant_reg + 2'd1;

`ifdef I2C_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_reg;

    assign timeout_hit = ((state_reg == ISSUE) || (state_reg == COLLECT)) &&
                         (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt_reg <= '0;
        end else if (grant_load || retry_go) begin
            to_cnt_reg <= '0;
        end else if ((state_reg == ISSUE) || (state_reg == COLLECT)) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
        end
    end
`else
    // Watchdog compiled out: the FSM waits indefinitely on the master.
    assign timeout_hit = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cmd_valid  = 1'b0;
        pkt_valid  = 1'b0;
        grant_load = 1'b0;
        issue_hs   = 1'b0;
        fail       = 1'b0;
        retry_go   = 1'b0;
        drop       = 1'b0;
        emit_hs    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|arb_grant) begin
                    grant_load = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    issue_hs   = 1'b1;
                    state_next = COLLECT;
                end else if (timeout_hit) begin
                    fail = 1'b1;
                end
            end
            COLLECT: begin
                if (timeout_hit || (xfer_done && (xfer_nack || short_read))) begin
                    fail = 1'b1;
                end else if (xfer_done) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                pkt_valid = 1'b1;
                if (pkt_ready) begin
                    emit_hs    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (fail) begin
            if (int'(retry_reg) < MAX_RETRY) begin
                retry_go   = 1'b1;
                state_next = ISSUE;
            end else begin
                drop       = 1'b1;
                state_next = IDLE;
            end
        end
    end

    // A wrap landing on the same cycle as a completion re-arms the slot for the new round.
    always_comb begin
        pending_next = pending_reg;
        if (drop || emit_hs) begin
            pending_next[grant_reg] = 1'b0;
        end
        if (period_wrap && enable) begin
            pending_next = pending_next | SLOT_MASK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period_cnt_reg <= '0;
            pending_reg    <= '0;
            ptr_reg        <= '0;
            grant_reg      <= '0;
            retry_reg      <= '0;
            byte_idx_reg   <= '0;
            ts_reg         <= '0;
            slot_id_reg    <= '0;
            cmd_dev_addr   <= '0;
            cmd_reg_addr   <= '0;
            cmd_len        <= '0;
            err_count      <= '0;
        end else begin
            period_cnt_reg <= period_wrap ? '0 : period_cnt_reg + 1'b1;
            pending_reg    <= pending_next;
            if (grant_load) begin
                grant_reg    <= arb_idx;
                retry_reg    <= '0;
                cmd_dev_addr <= arb_cfg.dev_addr;
                cmd_reg_addr <= arb_cfg.reg_addr;
                cmd_len      <= arb_cfg.len;
                slot_id_reg  <= arb_cfg.id;
            end
            if (issue_hs) begin
                ts_reg       <= timestamp;
                byte_idx_reg <= '0;
            end
            if (store) begin
                byte_idx_reg <= byte_idx_eff;
            end
            if (retry_go) begin
                retry_reg <= retry_reg + 8'd1;
            end
            if (drop) begin
                ptr_reg <= ptr_next;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
            if (emit_hs) begin
                ptr_reg <= ptr_next;
            end
        end
    end

    // Byte k of the read lands in payload[47-8k -: 8]; a retry or new grant wipes it.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_payload
            always_ff @(posedge clk) begin
                if (rst) begin
                    payload_bytes[gi] <= '0;
                end else if (grant_load || retry_go) begin
                    payload_bytes[gi] <= '0;
                end else if (store && (byte_idx_reg == 3'(gi))) begin
                    payload_bytes[gi] <= rd_data;
                end
            end
            assign payload_flat[PAYLOAD_W-1-8*gi -: 8] = payload_bytes[gi];
        end
    endgenerate

    assign pkt_data = {payload_flat, ts_reg, slot_id_reg};
    assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_i2c_sensor_scheduler.sv
// Directed bench for i2c_sensor_scheduler: table of NACK scenarios per round,
// plus hand sequences for back-pressure, mid-transfer reset and the watchdog.
module tb_i2c_sensor_scheduler;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [23:0] timestamp;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [6:0]  cmd_dev_addr;
    logic [7:0]  cmd_reg_addr;
    logic [2:0]  cmd_len;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        xfer_done;
    logic        xfer_nack;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [79:0] pkt_data;
    logic        busy;
    logic [7:0]  err_count;

    i2c_sensor_scheduler #(
        .NUM_SLOTS      (3),
        .PERIOD_CYCLES  (16),
        .MAX_RETRY      (2),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .timestamp    (timestamp),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_dev_addr (cmd_dev_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_len      (cmd_len),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .xfer_done    (xfer_done),
        .xfer_nack    (xfer_nack),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .pkt_data     (pkt_data),
        .busy         (busy),
        .err_count    (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors;
    int miscompares;

    // Master/sink model configuration (set by the test) and observation logs.
    int          nack_left [4];
    logic [3:0]  hang_mask;
    logic        sink_en;
    int          hs_count [4];
    logic [23:0] hs_ts [4];
    logic [7:0]  hs_reg [4];
    logic [2:0]  hs_len [4];
    logic [6:0]  hs_addr_q [$];
    logic [79:0] pkt_q [$];

    logic [6:0]  addr_tbl [3];
    logic [7:0]  reg_tbl [3];

    typedef struct {
        int          n0, n1, n2;
        int          c0, c1, c2;
        int          err;
        int          npkt;
        logic [23:0] ids;
    } vec_t;
    vec_t vt [4];

    function automatic int slot_of_addr(input logic [6:0] a);
        case (a)
            7'h1E:   return 0;
            7'h77:   return 1;
            7'h68:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int slot_of_id(input logic [7:0] id);
        case (id)
            8'h4D:   return 0;
            8'h42:   return 1;
            8'h41:   return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 4; i++) begin
            hs_count[i]  = 0;
            hs_ts[i]     = '0;
            hs_reg[i]    = '0;
            hs_len[i]    = '0;
            nack_left[i] = 0;
        end
        hs_addr_q.delete();
        pkt_q.delete();
        hang_mask = '0;
        sink_en   = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst    = 1'b1;
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Master + packet sink model: always-ready command port, six bytes 0x11..0x66,
    // a programmable number of NACKs per slot, optional hang (never completes).
    initial begin
        int m_state;
        int k;
        int cur;
        m_state = 0; k = 0; cur = 0;
        timestamp = '0;
        cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
        xfer_done = 1'b0; xfer_nack = 1'b0; pkt_ready = 1'b0;
        forever begin
            @(negedge clk);
            timestamp = timestamp + 24'd1;
            cmd_ready = 1'b0; rd_valid = 1'b0; rd_data = '0;
            xfer_done = 1'b0; xfer_nack = 1'b0;
            pkt_ready = sink_en;
            if (rst) begin
                m_state = 0;
            end else begin
                if (cmd_valid) begin
                    cmd_ready = 1'b1;
                    cur = slot_of_addr(cmd_dev_addr);
                    hs_addr_q.push_back(cmd_dev_addr);
                    hs_count[cur] = hs_count[cur] + 1;
                    hs_ts[cur]  = timestamp;
                    hs_reg[cur] = cmd_reg_addr;
                    hs_len[cur] = cmd_len;
                    m_state = 1;
                    k = 0;
                end else if (m_state == 1) begin
                    if (hang_mask[cur]) begin
                        m_state = 1;
                    end else if (nack_left[cur] > 0) begin
                        xfer_done = 1'b1;
                        xfer_nack = 1'b1;
                        nack_left[cur] = nack_left[cur] - 1;
                        m_state = 0;
                    end else if (k < 6) begin
                        rd_valid = 1'b1;
                        rd_data  = 8'(17 * (k + 1));
                        k++;
                    end else begin
                        xfer_done = 1'b1;
                        m_state = 0;
                    end
                end
                if (pkt_valid && pkt_ready) begin
                    pkt_q.push_back(pkt_data);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        enable = 1'b0;
        addr_tbl = '{7'h1E, 7'h77, 7'h68};
        reg_tbl  = '{8'h03, 8'hF7, 8'h3B};
        clear_logs();

        //          nacks     expected cmds  err npkt ids
        vt[0] = '{0, 0, 0,  1, 1, 1,  0, 3, 24'h4D4241};
        vt[1] = '{2, 0, 0,  3, 1, 1,  0, 3, 24'h4D4241};
        vt[2] = '{0, 3, 0,  1, 3, 1,  1, 2, 24'h4D4100};
        vt[3] = '{3, 3, 3,  3, 3, 3,  3, 0, 24'h000000};

        do_reset();
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_pkt_valid", pkt_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_err_count", err_count, 0);
        check("rst_pkt_data", pkt_data, 0);
        check("rst_cmd_addr", cmd_dev_addr, 0);

        for (int vi = 0; vi < 4; vi++) begin
            vec_t        v;
            int          c [3];
            int          pos;
            logic [23:0] ids;
            v = vt[vi];
            do_reset();
            clear_logs();
            nack_left[0] = v.n0;
            nack_left[1] = v.n1;
            nack_left[2] = v.n2;
            enable = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            enable = 1'b0;
            repeat (150) @(posedge clk);
            #1;
            $display("vector %0d: nacks %0d/%0d/%0d, %0d cmds, %0d pkts, err_count %0d",
                     vi, v.n0, v.n1, v.n2, hs_addr_q.size(), pkt_q.size(), err_count);
            ids = v.ids;
            check("pkt_count", pkt_q.size(), v.npkt);
            for (int j = 0; j < v.npkt; j++) begin
                if (j < pkt_q.size()) begin
                    logic [79:0] p;
                    int          s;
                    p = pkt_q[j];
                    s = slot_of_id(ids[23-8*j -: 8]);
                    check("pkt_id", p[7:0], ids[23-8*j -: 8]);
                    check("pkt_payload", p[79:32], 48'h112233445566);
                    check("pkt_ts", p[31:8], hs_ts[s]);
                end
            end
            c[0] = v.c0; c[1] = v.c1; c[2] = v.c2;
            check("cmd_total", hs_addr_q.size(), v.c0 + v.c1 + v.c2);
            pos = 0;
            for (int s = 0; s < 3; s++) begin
                check("cmd_count", hs_count[s], c[s]);
                if (c[s] > 0) begin
                    check("cmd_reg_addr", hs_reg[s], reg_tbl[s]);
                    check("cmd_len", hs_len[s], 3'd6);
                end
                for (int r = 0; r < c[s]; r++) begin
                    check("cmd_addr_seq", (pos < hs_addr_q.size()) ? hs_addr_q[pos] : 7'h00, addr_tbl[s]);
                    pos++;
                end
            end
            check("err_count", err_count, v.err);
            check("idle_after", busy, 0);
        end

        // Back-pressure: hold the M packet across several wraps, then drain.
        begin
            int          n;
            logic [79:0] hold;
            logic        stable;
            do_reset();
            clear_logs();
            sink_en = 1'b0;
            enable  = 1'b1;
            n = 0;
            while (!pkt_valid && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("stall_reach_emit", pkt_valid, 1);
            hold = pkt_data;
            check("stall_pkt_id", hold[7:0], 8'h4D);
            stable = 1'b1;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk); #1;
                if (!pkt_valid || pkt_data !== hold) stable = 1'b0;
            end
            check("stall_stable", stable, 1);
            enable  = 1'b0;
            sink_en = 1'b1;
            repeat (150) @(posedge clk);
            #1;
            $display("stall: held %h for 40 cycles, %0d pkts after release", hold, pkt_q.size());
            check("stall_pkt_count", pkt_q.size(), 3);
            for (int j = 0; j < 3; j++) begin
                logic [23:0] exp_ids;
                logic [79:0] p;
                exp_ids = 24'h4D4241;
                p = (j < pkt_q.size()) ? pkt_q[j] : 80'h0;
                check("stall_pkt_order", p[7:0], exp_ids[23-8*j -: 8]);
            end
        end

        // Reset while slot2 is stuck in COLLECT, after slot1 has been dropped.
        begin
            int n;
            do_reset();
            clear_logs();
            nack_left[1] = 3;
            hang_mask    = 4'b0100;
            enable       = 1'b1;
            n = 0;
            while (hs_count[2] < 1 && n < 200) begin
                @(posedge clk); #1;
                n++;
            end
            repeat (2) @(posedge clk);
            #1;
            check("pre_rst_busy", busy, 1);
            check("pre_rst_err", err_count, 1);
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            $display("mid-collect reset: cmd_valid %0d pkt_valid %0d busy %0d err_count %0d",
                     cmd_valid, pkt_valid, busy, err_count);
            check("rst_mid_cmd_valid", cmd_valid, 0);
            check("rst_mid_pkt_valid", pkt_valid, 0);
            check("rst_mid_err", err_count, 0);
            check("rst_mid_busy", busy, 0);
            clear_logs();
            enable = 1'b1;
            n = 0;
            while (hs_addr_q.size() < 1 && n < 60) begin
                @(posedge clk); #1;
                n++;
            end
            enable = 1'b0;
            check("rst_first_grant", (hs_addr_q.size() > 0) ? hs_addr_q[0] : 7'h00, 7'h1E);
            repeat (150) @(posedge clk);
            #1;
        end

`ifdef I2C_SCHED_TIMEOUT_EN
        // Slot0 never completes: three watchdog expiries then a drop.
        do_reset();
        clear_logs();
        hang_mask = 4'b0001;
        enable    = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        enable = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        $display("timeout: %0d slot0 cmds, err_count %0d, %0d pkts", hs_count[0], err_count, pkt_q.size());
        check("to_cmd_count", hs_count[0], 3);
        check("to_err_count", err_count, 1);
        check("to_pkt_count", pkt_q.size(), 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_sensor_scheduler.md
Name: i2c_sensor_scheduler

Overview:
Sequences the shared I2C byte-level master across up to three sensor slots: magnetometer, barometer and accelerometer.
- A period counter marks every slot pending.
- A round-robin arbiter grants one slot at a time and issues a read command.
- Returned bytes are collected, timestamped and emitted as 80-bit packets {payload[47:0], timestamp[23:0], id[7:0]} to the memory writer.

Parameters:
NUM_SLOTS, 3, active slots (1..3); slot table entries at or above NUM_SLOTS are ignored
PERIOD_CYCLES, 100000, clk cycles between sampling rounds (>=16)
MAX_RETRY, 2, reissues after a NACK before the slot is dropped for this round
TIMEOUT_CYCLES, 4096, watchdog limit per transfer (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
enable  in  1  high = period ticks set pending bits
timestamp  in  24  free-running mission time
cmd_valid  out  1  command request to I2C master
cmd_ready  in  1  master accepts command
cmd_dev_addr  out  7  7-bit device address
cmd_reg_addr  out  8  first register to read
cmd_len  out  3  byte count (1..6)
rd_valid  in  1  one read byte valid
rd_data  in  8  read byte
xfer_done  in  1  one-cycle pulse: transfer finished with STOP
xfer_nack  in  1  qualifies xfer_done: slave NACKed
pkt_valid  out  1  packet available
pkt_ready  in  1  memory writer accepts packet
pkt_data  out  80  {payload, ts, id}
busy  out  1  FSM not in IDLE
err_count  out  8  saturating count of dropped transfers

Behaviour:
Reset (rst high at a clk edge):
- All outputs are 0; pending bits and retry count are 0; the round-robin pointer is 0; the period counter is 0; state is IDLE.
- Reset mid-transfer drops cmd_valid/pkt_valid the following cycle; the master must be reset in the same cycle.

Period counter:
- Counts 0..PERIOD_CYCLES-1 and wraps.
- On wrap with enable high, pending[i] is set for all i<NUM_SLOTS.
- If pending[i] is already set at that wrap, it stays set (no queueing).

FSM states:
- IDLE:
  - If any pending bit is set, grant the first pending slot searching from ptr upward with wrap.
  - Load cmd_* from the slot table, clear payload, retry=0, go to ISSUE.
  - Grant decision takes 1 cycle; cmd_valid rises the cycle after the pending bit is visible.
- ISSUE:
  - cmd_valid=1 with stable fields until cmd_ready.
  - On handshake: capture timestamp, byte index=0, go to COLLECT.
- COLLECT:
  - Each rd_valid stores rd_data into payload[47-8k -: 8] for k=index, then index++.
  - Bytes beyond cmd_len are ignored; unused low payload bytes stay 0.
  - On xfer_done without nack and index==cmd_len: go to EMIT.
  - On xfer_done with nack, or a short read (index<cmd_len):
    - If retry<MAX_RETRY: retry++, clear payload, go to ISSUE (the timestamp is recaptured).
    - Otherwise: err_count++ (saturates at 255), clear pending[grant], ptr=grant+1 mod NUM_SLOTS, go to IDLE.
  - rd_valid and xfer_done in the same cycle: the byte is stored first, then the completion check runs.
- EMIT:
  - pkt_valid=1, pkt_data={payload, ts_captured, slot id}, held stable until pkt_ready.
  - On handshake: clear pending[grant], ptr=grant+1 mod NUM_SLOTS, go to IDLE.
  - Pending bits keep accumulating while stalled here.

Other rules:
- enable low blocks only new pending bits; an in-flight transfer and existing pending bits complete normally.
- busy = (state != IDLE).

Optional Feature:
Macro I2C_SCHED_TIMEOUT_EN.
- Defined: a counter clears on entry to ISSUE and increments each cycle in ISSUE and COLLECT. Reaching TIMEOUT_CYCLES is treated exactly as a NACK, including the retry/drop path, and abandons the command.
- Undefined: no counter; the FSM waits indefinitely for cmd_ready or xfer_done.

Decomposition:
Shared package i2c_sched_pkg:
- State encoding: IDLE, ISSUE, COLLECT, EMIT.
- Slot table constants:
  - slot0: mag 0x1E, reg 0x03, len 6, id 0x4D 'M'
  - slot1: baro 0x77, reg 0xF7, len 6, id 0x42 'B'
  - slot2: accel 0x68, reg 0x3B, len 6, id 0x41 'A'
- Packet field widths.
Sub-module rr_arbiter3: pending[2:0] and ptr in, one-hot grant plus index out, purely combinational.

Test Plan:
- PERIOD_CYCLES=16, master model always ACKs, bytes 0x11..0x66 -> three packets in order M,B,A. The M packet is {0x112233445566, ts at cmd accept, 0x4D}. cmd_dev_addr sequence is 0x1E, 0x77, 0x68.
- Slot0 NACKs twice then ACKs (MAX_RETRY=2) -> three cmd handshakes for slot0, one M packet, err_count=0.
- Slot1 NACKs three times -> no B packet, err_count=1, next grant is slot2.
- pkt_ready held low 40 cycles across two period wraps -> pkt_data stable; after release, B and A are each emitted once (no duplicates).
- rst pulsed during COLLECT -> the next cycle has cmd_valid=0, pkt_valid=0, err_count=0, busy=0; the first grant after reset is slot0.
- With I2C_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=32, master never asserts xfer_done -> after 3×32 cycles the slot is dropped and err_count=1.
